// File: rtl/sisi_dff_if.sv
// Serial bit-stream interface for the sisi_dff delay line.
// The producer side drives Din; the delay line drives Sout back.
interface sisi_dff_if;
    logic Din;
    logic Sout;

    // Serial producer/consumer side: drives data in, observes the delayed stream.
    modport master (
        output Din,
        input  Sout
    );

    // Delay-line side: samples Din and presents the delayed bit on Sout.
    modport slave (
        input  Din,
        output Sout
    );
endinterface

// File: rtl/sisi_dff.sv
// Serial-in serial-out shift register: a chain of WIDTH D flip-flops.
// A bit sampled on Din leaves on Sout exactly WIDTH rising edges later.
// Stage 0 is the input stage and stage WIDTH-1 drives Sout directly, so
// there is no combinational path from Din to Sout. WIDTH must be at least 1;
// with WIDTH=1 the chain is a single D flip-flop.
module sisi_dff #(
    parameter int WIDTH = 4
) (
    input logic      CLK,
    input logic      RST_N,
    sisi_dff_if.slave bus
);

    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;

    // Next chain contents: Din enters stage 0 and every other stage takes its predecessor.
    always_comb begin
        shift_d    = shift_q;
        shift_d[0] = bus.Din;
        for (int i = 1; i < WIDTH; i++) begin
            shift_d[i] = shift_q[i-1];
        end
    end

    // Chain register: cleared at once by reset, otherwise shifts on every rising edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            shift_q <= '0;
        end else begin
            shift_q <= shift_d;
        end
    end

    assign bus.Sout = shift_q[WIDTH-1];

endmodule

// File: tb/tb_sisi_dff.sv
// Self-checking bench for sisi_dff: three instances (WIDTH 1, 4 and 8) share
// one clock, reset and Din stream. A reference model records every sampled
// Din bit since reset and predicts Sout as the bit sampled WIDTH-1 edges
// earlier (zero before enough edges have elapsed); predictions are queued
// and a negedge monitor pops and compares them against each Sout.
module tb_sisi_dff;

    localparam int NDUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic din   = 1'b0;

    int checks   = 0;
    int failures = 0;

    int widths [NDUT] = '{1, 4, 8};

    bit hist  [NDUT][$];
    bit exp_q [NDUT][$];
    int edge_cnt [NDUT];

    sisi_dff_if u_if1 ();
    sisi_dff_if u_if4 ();
    sisi_dff_if u_if8 ();

    assign u_if1.Din = din;
    assign u_if4.Din = din;
    assign u_if8.Din = din;

    sisi_dff #(.WIDTH(1)) u_dut1 (.CLK(clk), .RST_N(rst_n), .bus(u_if1.slave));
    sisi_dff #(.WIDTH(4)) u_dut4 (.CLK(clk), .RST_N(rst_n), .bus(u_if4.slave));
    sisi_dff #(.WIDTH(8)) u_dut8 (.CLK(clk), .RST_N(rst_n), .bus(u_if8.slave));

    // 20 ns clock with rising edges at 10, 30, 50, ...
    always #10 clk = ~clk;

    function automatic logic sout_of(int d);
        case (d)
            0:       return u_if1.Sout;
            1:       return u_if4.Sout;
            default: return u_if8.Sout;
        endcase
    endfunction

    task automatic check_output(string name, logic actual, logic expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    // Step to the next rising edge and change Din 5 ns after it, between edges.
    task automatic apply_stimulus(logic b);
        @(posedge clk);
        #5 din = b;
    endtask

    // Reference model: on each active edge record the sampled bit and predict Sout.
    always @(posedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (rst_n) begin
                hist[d].push_back(din);
                edge_cnt[d]++;
                if (edge_cnt[d] >= widths[d])
                    exp_q[d].push_back(hist[d][edge_cnt[d] - widths[d]]);
                else
                    exp_q[d].push_back(1'b0);
            end else begin
                exp_q[d].push_back(1'b0);
            end
        end
    end

    // Reset discards the history and any pending prediction; Sout is zero at once.
    always @(negedge rst_n) begin
        for (int d = 0; d < NDUT; d++) begin
            hist[d].delete();
            edge_cnt[d] = 0;
            exp_q[d].delete();
            exp_q[d].push_back(1'b0);
        end
    end

    // Monitor: compare each presented Sout with the oldest queued prediction.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (exp_q[d].size() > 0) begin
                logic e;
                e = exp_q[d].pop_front();
                check_output($sformatf("sb_w%0d", widths[d]), sout_of(d), e);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic stream_exp [7];
        int   highs;

        stream_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        for (int d = 0; d < NDUT; d++) edge_cnt[d] = 0;

        // Reset state before any clock.
        #1;
        check_output("reset_w1", u_if1.Sout, 1'b0);
        check_output("reset_w4", u_if4.Sout, 1'b0);
        check_output("reset_w8", u_if8.Sout, 1'b0);
        #4 rst_n = 1'b1;

        // Directed latency stream for WIDTH=4.
        #10 din = 1'b1;
        #20 din = 1'b0;
        #20 din = 1'b1;
        #20 din = 1'b1;
        wait (($time) >= 140);
        #0;
        check_output("stream_w4_after130", u_if4.Sout, stream_exp[6]);
        #1;
        check_output("stream_w4_hold", u_if4.Sout, 1'b1);

        // Reset held with Din=1 for three clocks keeps every chain at zero.
        apply_stimulus(1'b1);
        rst_n = 1'b0;
        #1;
        check_output("async_rst_w4", u_if4.Sout, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("held_rst_w1", u_if1.Sout, 1'b0);
            check_output("held_rst_w8", u_if8.Sout, 1'b0);
        end
        @(posedge clk);
        #5 rst_n = 1'b1;
        din = 1'b0;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0);

        // Single pulse: each Sout must be high for exactly one cycle.
        apply_stimulus(1'b1);
        highs = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(1'b0);
            #5 if (u_if8.Sout === 1'b1) highs++;
        end
        checks++;
        if (highs != 1) begin
            failures++;
            $display("[TB] FAIL pulse_w8_width: got %0d high cycles, expected 1", highs);
        end

        // Mid-stream reset after shifting in 1111.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1);
        apply_stimulus(1'b1);
        #4;
        check_output("pre_rst_w4", u_if4.Sout, 1'b1);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_w1", u_if1.Sout, 1'b0);
        check_output("mid_rst_w4", u_if4.Sout, 1'b0);
        check_output("mid_rst_w8", u_if8.Sout, 1'b0);
        din = 1'b0;
        @(posedge clk);
        #5 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0);

        // Random bit stream for all widths.
        for (int i = 0; i < 150; i++) apply_stimulus(1'($urandom_range(0, 1)));

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Directed checks of the WIDTH=4 latency stream after the edges at 10..110 ns.
    initial begin
        logic s_exp [6];
        s_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        #20;
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("stream_w4_t%0d", 20 + 20 * i), u_if4.Sout, s_exp[i]);
            #20;
        end
    end

endmodule
